// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the LC-3 writeback stage.
// Also provides the NZP condition-code helper.
package writeback_stage_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PC   = 2'd1,
    WB_MEM  = 2'd2,
    WB_RSVD = 2'd3
  } w_ctrl_t;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  function automatic logic [2:0] nzp_of(input logic [15:0] value);
    if (value[15])
      return PSR_N;
    else if (value == 16'h0000)
      return PSR_Z;
    else
      return PSR_P;
  endfunction

endpackage

// File: rtl/writeback_stage_regfile.sv
// 8 x 16-bit general-purpose register file: one synchronous write port,
// two asynchronous read ports, synchronous active-low clear.
module writeback_regfile
  import writeback_stage_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr1,
  input  logic [REG_ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0]     o_rdata1,
  output logic [DATA_W-1:0]     o_rdata2
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads see stored state only, so a same-cycle write is not forwarded.
  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/writeback_stage.sv
// LC-3 writeback: selects the result source, commits it to the register
// file and updates the NZP status register on the same edge.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_writeback,
  input  logic [1:0]  W_Control,
  input  logic [15:0] aluout,
  input  logic [15:0] pcout,
  input  logic [15:0] memout,
  input  logic [2:0]  dr,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  output logic [15:0] VSR1,
  output logic [15:0] VSR2,
  output logic [2:0]  psr
);

  logic [DATA_W-1:0] w_dr_in;
  logic              w_we;
  logic [2:0]        r_psr;

  always_comb begin
    w_dr_in = '0;
    case (W_Control)
      WB_ALU:  w_dr_in = aluout;
      WB_PC:   w_dr_in = pcout;
      WB_MEM:  w_dr_in = memout;
      default: w_dr_in = '0;
    endcase
  end

  // The reserved source code is a silent no-op.
  assign w_we = enable_writeback && (W_Control != WB_RSVD);

  always_ff @(posedge clock) begin
    if (!reset)
      r_psr <= 3'b000;
    else if (w_we)
      r_psr <= nzp_of(w_dr_in);
  end

  assign psr = r_psr;

  writeback_regfile u_regfile (
    .clock    (clock),
    .reset    (reset),
    .i_we     (w_we),
    .i_waddr  (dr),
    .i_wdata  (w_dr_in),
    .i_raddr1 (sr1),
    .i_raddr2 (sr2),
    .o_rdata1 (VSR1),
    .o_rdata2 (VSR2)
  );

endmodule
